// File: rtl/cnn_two_layer.sv
// rtl/cnn_two_layer.sv - two-stage streaming 1-D convolution engine with serial readout
module cnn_two_layer #(
  parameter int IMG_W = 4,
  parameter int F1_W  = 4,
  parameter int L1_W  = 10,
  parameter int F2_W  = 10,
  parameter int OUT_W = 22,
  parameter int TAPS  = 3,
  parameter int NOUT  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    Start1,
  input  logic        [IMG_W-1:0] Image,
  input  logic signed [F1_W-1:0]  Filter1,
  input  logic                    ReadEn1,
  input  logic                    Start2,
  input  logic signed [F2_W-1:0]  Filter2,
  input  logic                    ReadEn2,
  output logic signed [OUT_W-1:0] ConvResult
);

  localparam logic [1:0] LAST_TAP = 2'(TAPS - 1);
  localparam logic [2:0] N_C      = 3'(NOUT);
  localparam logic [2:0] LAST_IDX = 3'(NOUT - 1);

  // Layer-1 state: tap position, output index, running sum, buffer, burst edge detect
  logic [1:0]              tap1_q, tap1_d;
  logic [2:0]              idx1_q, idx1_d;
  logic signed [L1_W-1:0]  acc1_q, acc1_d;
  logic signed [L1_W-1:0]  l1_q [NOUT];
  logic signed [L1_W-1:0]  l1_d [NOUT];
  logic                    start1_q, start1_d;

  // Layer-2 state
  logic [1:0]              tap2_q, tap2_d;
  logic [2:0]              idx2_q, idx2_d;
  logic signed [OUT_W-1:0] acc2_q, acc2_d;
  logic signed [OUT_W-1:0] r_q [NOUT];
  logic signed [OUT_W-1:0] r_d [NOUT];
  logic                    start2_q, start2_d;

  // Readout state
  logic [2:0]              ptr_q, ptr_d;
  logic signed [OUT_W-1:0] conv_q, conv_d;

  logic signed [IMG_W+F1_W:0]   prod1;
  logic signed [L1_W-1:0]       sum1;
  logic [2:0]                   lidx;
  logic signed [L1_W-1:0]       lv;
  logic signed [F2_W+L1_W-1:0]  prod2;
  logic signed [OUT_W-1:0]      sum2;

  // Product/sum datapaths; a new group restarts the sum from the product alone
  always_comb begin
    prod1 = $signed({1'b0, Image}) * Filter1;
    sum1  = ((tap1_q == 2'd0) ? '0 : acc1_q) + L1_W'(prod1);
    lidx  = idx2_q + {1'b0, tap2_q};
    lv    = (ReadEn1 && (lidx < N_C)) ? l1_q[lidx] : '0;
    prod2 = Filter2 * lv;
    sum2  = ((tap2_q == 2'd0) ? '0 : acc2_q) + OUT_W'(prod2);
  end

  // Layer 1: accumulate 3-tap dot products into the L1 buffer
  always_comb begin
    tap1_d   = tap1_q;
    idx1_d   = idx1_q;
    acc1_d   = acc1_q;
    l1_d     = l1_q;
    start1_d = Start1;
    if (!Start1) begin
      tap1_d = '0;
      idx1_d = '0;
      acc1_d = '0;
    end else begin
      if (!start1_q) begin
        for (int i = 0; i < NOUT; i++) l1_d[i] = '0;
      end
      if (idx1_q < N_C) begin
        acc1_d = sum1;
        if (tap1_q == LAST_TAP) begin
          l1_d[idx1_q] = sum1;
          tap1_d       = '0;
          idx1_d       = idx1_q + 3'd1;
        end else begin
          tap1_d = tap1_q + 2'd1;
        end
      end
    end
  end

  // Layer 2: correlate filter taps against a sliding, zero-padded L1 window
  always_comb begin
    tap2_d   = tap2_q;
    idx2_d   = idx2_q;
    acc2_d   = acc2_q;
    r_d      = r_q;
    start2_d = Start2;
    if (!Start2) begin
      tap2_d = '0;
      idx2_d = '0;
      acc2_d = '0;
    end else begin
      if (!start2_q) begin
        for (int i = 0; i < NOUT; i++) r_d[i] = '0;
      end
      if (idx2_q < N_C) begin
        acc2_d = sum2;
        if (tap2_q == LAST_TAP) begin
          r_d[idx2_q] = sum2;
          tap2_d      = '0;
          idx2_d      = idx2_q + 3'd1;
        end else begin
          tap2_d = tap2_q + 2'd1;
        end
      end
    end
  end

  // Serial readout with wrapping pointer; idle holds the output and rewinds
  always_comb begin
    ptr_d  = ptr_q;
    conv_d = conv_q;
    if (ReadEn2) begin
      conv_d = r_q[ptr_q];
      ptr_d  = (ptr_q == LAST_IDX) ? 3'd0 : ptr_q + 3'd1;
    end else begin
      ptr_d = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tap1_q   <= '0;
      idx1_q   <= '0;
      acc1_q   <= '0;
      l1_q     <= '{default: '0};
      start1_q <= 1'b0;
      tap2_q   <= '0;
      idx2_q   <= '0;
      acc2_q   <= '0;
      r_q      <= '{default: '0};
      start2_q <= 1'b0;
      ptr_q    <= '0;
      conv_q   <= '0;
    end else begin
      tap1_q   <= tap1_d;
      idx1_q   <= idx1_d;
      acc1_q   <= acc1_d;
      l1_q     <= l1_d;
      start1_q <= start1_d;
      tap2_q   <= tap2_d;
      idx2_q   <= idx2_d;
      acc2_q   <= acc2_d;
      r_q      <= r_d;
      start2_q <= start2_d;
      ptr_q    <= ptr_d;
      conv_q   <= conv_d;
    end
  end

  assign ConvResult = conv_q;

endmodule

// File: tb/tb_cnn_two_layer.sv
// tb/tb_cnn_two_layer.sv - scoreboard bench for cnn_two_layer against an arithmetic reference model
module tb_cnn_two_layer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               Start1, ReadEn1, Start2, ReadEn2;
  logic        [3:0]  Image;
  logic signed [3:0]  Filter1;
  logic signed [9:0]  Filter2;
  logic signed [21:0] ConvResult;

  cnn_two_layer dut (
    .clk(clk), .rst_n(rst_n), .Start1(Start1), .Image(Image), .Filter1(Filter1),
    .ReadEn1(ReadEn1), .Start2(Start2), .Filter2(Filter2), .ReadEn2(ReadEn2),
    .ConvResult(ConvResult)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_q[$];
  int m_l1[5];
  int m_r[5];
  int rd_ptr;
  int last_exp;
  bit rd_fire = 1'b0;
  int img[18];
  int f1[18];
  int f2[15];

  function automatic int wrap10(int v);
    logic signed [9:0] t;
    t = v[9:0];
    return int'(t);
  endfunction

  function automatic int wrap22(int v);
    logic signed [21:0] t;
    t = v[21:0];
    return int'(t);
  endfunction

  task automatic check(string name, int got, int req);
    n_tests++;
    if (got != req) begin
      n_fail++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // a readout registered at the previous posedge is compared at the negedge
  always @(posedge clk) rd_fire <= ReadEn2 && rst_n;

  always @(negedge clk) begin
    if (rd_fire) begin
      int got;
      got = ConvResult;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL readout_unexpected got=%0d required=none", got);
      end else begin
        check("readout", got, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    Start1 = 1'b0;
    Start2 = 1'b0;
    ReadEn2 = 1'b0;
    tick();
    check("reset_conv", ConvResult, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      m_l1[i] = 0;
      m_r[i]  = 0;
    end
    rd_ptr = 0;
  endtask

  task automatic run_l1(int n);
    for (int i = 0; i < n; i++) begin
      Start1  = 1'b1;
      Image   = 4'(img[i]);
      Filter1 = 4'(f1[i]);
      tick();
    end
    Start1 = 1'b0;
    tick();
    if (n > 0) begin
      for (int g = 0; g < 5; g++) begin
        m_l1[g] = 0;
        if (3 * g + 2 < n)
          m_l1[g] = wrap10(img[3*g]*f1[3*g] + img[3*g+1]*f1[3*g+1] + img[3*g+2]*f1[3*g+2]);
      end
    end
  endtask

  task automatic run_l2(int n, bit re1);
    ReadEn1 = re1;
    for (int i = 0; i < n; i++) begin
      Start2  = 1'b1;
      Filter2 = 10'(f2[i]);
      tick();
    end
    Start2 = 1'b0;
    tick();
    if (n > 0) begin
      for (int j = 0; j < 5; j++) begin
        int s;
        s = 0;
        for (int t = 0; t < 3; t++)
          if (re1 && (j + t) < 5) s += f2[3*j+t] * m_l1[j+t];
        m_r[j] = (3 * j + 2 < n) ? wrap22(s) : 0;
      end
    end
  endtask

  task automatic readout(int cnt);
    for (int i = 0; i < cnt; i++) begin
      ReadEn2 = 1'b1;
      exp_q.push_back(m_r[rd_ptr]);
      last_exp = m_r[rd_ptr];
      rd_ptr = (rd_ptr + 1) % 5;
      tick();
    end
    ReadEn2 = 1'b0;
    rd_ptr = 0;
    tick();
    tick();
    check("queue_drained", exp_q.size(), 0);
    if (cnt > 0) check("hold", ConvResult, last_exp);
  endtask

  task automatic load_directed();
    int di[15] = '{1,2,3,2,3,4,3,4,5,4,5,6,5,6,7};
    int df[15] = '{1,2,3,-3,-2,-1,1,2,3,-5,5,-7,1,2,3};
    int dg[15] = '{1,2,3,-1,-2,-3,4,5,6,-4,-5,-6,7,8,9};
    for (int i = 0; i < 18; i++) begin
      img[i] = (i < 15) ? di[i] : int'($urandom_range(0, 15));
      f1[i]  = (i < 15) ? df[i] : int'($urandom_range(0, 15)) - 8;
    end
    for (int i = 0; i < 15; i++) f2[i] = dg[i];
  endtask

  initial begin
    Start1 = 0; Start2 = 0; ReadEn1 = 0; ReadEn2 = 0; rst_n = 0;
    Image = 0; Filter1 = 0; Filter2 = 0;
    last_exp = 0;
    tick();
    do_reset();
    readout(5);

    // directed layer-1 / layer-2 with wrap past the fifth result
    load_directed();
    run_l1(15);
    check("l1_model_0", m_l1[0], 14);
    check("l1_model_4", m_l1[4], 38);
    run_l2(15, 1'b1);
    readout(6);

    // ReadEn1 low -> all zeros
    run_l2(15, 1'b0);
    readout(5);

    // over-long and truncated layer-1 bursts
    run_l1(18);
    run_l2(15, 1'b1);
    readout(5);
    run_l1(7);
    run_l2(15, 1'b1);
    readout(5);

    // reset in the middle of a layer-2 burst, then a clean re-run
    run_l1(15);
    ReadEn1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      Start2 = 1'b1;
      Filter2 = 10'(f2[i]);
      tick();
    end
    do_reset();
    readout(5);
    run_l1(15);
    run_l2(15, 1'b1);
    readout(5);

    // randomized passes
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 18; i++) begin
        img[i] = int'($urandom_range(0, 15));
        f1[i]  = int'($urandom_range(0, 15)) - 8;
      end
      for (int i = 0; i < 15; i++) f2[i] = int'($urandom_range(0, 1023)) - 512;
      run_l1(int'($urandom_range(0, 18)));
      run_l2(int'($urandom_range(0, 17)), 1'($urandom_range(0, 3) != 0));
      readout(int'($urandom_range(1, 12)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
